mul_div_ctrl: RTL
=================

// Module: mul_div_ctrl
// PURPOSE
//  Execute-stage sequencer upstream of the iterative multiply/divide unit (mul_div).
//  - Accepts one M-extension instruction from issue.
//  - Drives the unit's req/operand/sign inputs and holds them stable until the unit signals ready.
//  - Selects the RV32M result half and returns it on a valid/ready writeback handshake.
//  - Stalls issue while busy.
// PARAMETERS
//  XLEN   32  operand/result width; fixed to match mul_div
//  RD_W   5   destination register index width
// PORTS
//  clk_i             in   1     clock, single clock domain
//  rst_i             in   1     synchronous active-high reset
//  issue_valid_i     in   1     instruction offered
//  issue_ready_o     out  1     (state==IDLE) & ~rst_i & ~flush_i
//  issue_op_i        in   7     opcode; only `INST_TYPE_R_M is accepted
//  issue_funct3_i    in   3     RV32M funct3
//  issue_rs1_i       in   XLEN  operand 1
//  issue_rs2_i       in   XLEN  operand 2
//  issue_rd_i        in   RD_W  destination register
//  flush_i           in   1     abort in-flight op; no writeback
//  md_req_o          out  1     = (state==BUSY)
//  md_op_o           out  7     latched opcode
//  md_m_d_op_o       out  3     latched funct3
//  md_rs1_o/md_rs2_o out  XLEN  latched operands
//  md_rs1_signed_o   out  1     mul: f3!=011; div: ~f3[0]
//  md_rs2_signed_o   out  1     mul: ~f3[1]; div: ~f3[0]
//  md_high_i/md_low_i in  XLEN  unit result (high=mulhi/remainder, low=mullo/quotient)
//  md_ready_i        in   1     unit done; sampled only in BUSY
//  wb_valid_o        out  1     = (state==RESP)
//  wb_ready_i        in   1     writeback accepts
//  wb_rd_o           out  RD_W  latched rd
//  wb_data_o         out  XLEN  selected result, registered
//  busy_o            out  1     = (state!=IDLE)
// BEHAVIOUR
//  - Reset: state=IDLE. All md_*, wb_* and busy_o are 0. Operand, rd and data registers are 0.
//  - States:
//    - IDLE: accept on issue_valid_i & issue_ready_o & op==`INST_TYPE_R_M. Latch funct3, rs1, rs2, rd. Go to BUSY.
//    - BUSY: hold md_* stable. On md_ready_i, register the result into wb_data_o and go to RESP.
//      - mul: f3==000 takes low; any other mul f3 takes high.
//      - div: f3[1]==0 takes low; f3[1]==1 takes high.
//    - RESP: md_req_o=0. On wb_ready_i go to IDLE. Otherwise hold wb_rd_o and wb_data_o stable.
//  - Unit re-arm: md_req_o is low for at least 1 clock between ops (RESP and IDLE each last at least 1 cycle).
//    The unit clears its count on that edge. Back-to-back issue is legal.
//  - Latency, counted from the accept edge:
//    - wb_valid_o rises 33 clocks later for non-zero operands.
//    - wb_valid_o rises 2 clocks later if either operand is 0.
//    - Only md_ready_i is relied on, never a fixed count.
//  - Special results come from the unit unmodified:
//    - x/0: quotient=FFFFFFFF, remainder=rs1.
//    - 80000000/FFFFFFFF: quotient=80000000, remainder=0.
//  - flush_i (priority over wb_ready_i and issue): any state goes to IDLE next edge, with no wb_valid_o for the aborted op.
//  - rst_i mid-BUSY: IDLE next edge; md_req_o low clears the unit.
//  - Non-`INST_TYPE_R_M opcode: never accepted; issue_ready_o stays high.
// CONFIGURATION
//  MUL_DIV_CTRL_REUSE_EN
//  - Defined:
//    - Keep the last completed op's rs1, rs2, key, high and low, plus a valid bit. valid is cleared by reset only; a flushed op never updates the entry.
//    - key: mul f3 000/001 map to 000, else f3; div maps to {1,0,f3[0]}.
//    - Accept with equal rs1, rs2 and key, with valid=1: go IDLE->RESP directly, md_req_o stays 0, wb_valid_o 1 clock after accept.
//    - The result half is selected from the stored entry.
//  - Undefined: no storage; every op goes through BUSY.
// TESTING
//  - MUL 7*(-3): f3=000 -> wb_data_o=FFFFFFEB, wb_valid_o 33 clks after accept.
//  - MULHU FFFFFFFF*FFFFFFFF: f3=011 -> FFFFFFFE.
//  - MULH same operands: f3=001 -> 00000000.
//  - DIV/REM -7/2 -> FFFFFFFD / FFFFFFFF.
//  - DIVU 5/0 -> FFFFFFFF; REMU 5/0 -> 5; wb_valid_o 2 clks after accept.
//  - DIV 80000000/FFFFFFFF -> 80000000.
//  - flush_i 10 clks into BUSY -> no wb_valid_o; md_req_o low at least 1 clk.
//    Then a MUL 3*4 -> 0000000C (stale count must not corrupt).
//  - wb_ready_i held 0 for 5 clks in RESP -> wb_data_o and wb_rd_o stable; issue_ready_o=0.
//  - REUSE_EN: MULH then MUL on the same operands -> second op has wb_valid_o 1 clk after accept and md_req_o never rises.
//    Correct low word returned.

Source files
------------

// File: rtl/mul_div_ctrl_if.sv
// Bundle between mul_div_ctrl and its neighbours: issue, the iterative mul_div unit, and writeback.
// The slave modport is the controller's view; master is the surrounding pipeline and unit.
`ifndef INST_TYPE_R_M
`define INST_TYPE_R_M 7'b0110011
`endif

interface mul_div_ctrl_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [6:0]      issue_op_i;
    logic [2:0]      issue_funct3_i;
    logic [XLEN-1:0] issue_rs1_i;
    logic [XLEN-1:0] issue_rs2_i;
    logic [RD_W-1:0] issue_rd_i;
    logic            flush_i;

    logic            md_req_o;
    logic [6:0]      md_op_o;
    logic [2:0]      md_m_d_op_o;
    logic [XLEN-1:0] md_rs1_o;
    logic [XLEN-1:0] md_rs2_o;
    logic            md_rs1_signed_o;
    logic            md_rs2_signed_o;
    logic [XLEN-1:0] md_high_i;
    logic [XLEN-1:0] md_low_i;
    logic            md_ready_i;

    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [RD_W-1:0] wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            busy_o;

    modport slave (
        input  issue_valid_i, issue_op_i, issue_funct3_i, issue_rs1_i, issue_rs2_i, issue_rd_i, flush_i,
        output issue_ready_o,
        output md_req_o, md_op_o, md_m_d_op_o, md_rs1_o, md_rs2_o, md_rs1_signed_o, md_rs2_signed_o,
        input  md_high_i, md_low_i, md_ready_i,
        output wb_valid_o, wb_rd_o, wb_data_o, busy_o,
        input  wb_ready_i
    );

    modport master (
        output issue_valid_i, issue_op_i, issue_funct3_i, issue_rs1_i, issue_rs2_i, issue_rd_i, flush_i,
        input  issue_ready_o,
        input  md_req_o, md_op_o, md_m_d_op_o, md_rs1_o, md_rs2_o, md_rs1_signed_o, md_rs2_signed_o,
        output md_high_i, md_low_i, md_ready_i,
        input  wb_valid_o, wb_rd_o, wb_data_o, busy_o,
        output wb_ready_i
    );
endinterface

// File: rtl/mul_div_ctrl.sv
// Execute-stage sequencer for one RV32M op through the iterative mul_div unit; optional last-result reuse via MUL_DIV_CTRL_REUSE_EN.
// Latency: md_ready_i plus one registered clock (typically 33, or 2 with a zero operand); a reuse hit responds on the accept edge.
// Backpressure: issue stalls while busy; the result is held on wb until wb_ready_i; flush_i aborts from any state.
`ifndef INST_TYPE_R_M
`define INST_TYPE_R_M 7'b0110011
`endif

module mul_div_ctrl #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mul_div_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      op_q, op_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            rs1_sgn_q, rs1_sgn_d;
    logic            rs2_sgn_q, rs2_sgn_d;
    logic            accept;

    // High half carries mulh*/remainder; low half carries mul/quotient.
    function automatic logic take_high(input logic [2:0] f3);
        return f3[2] ? f3[1] : (f3 != 3'b000);
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : ~f3[1];
    endfunction

    assign accept = (state_q == ST_IDLE) && bus.issue_valid_i && !bus.flush_i &&
                    (bus.issue_op_i == `INST_TYPE_R_M);

`ifdef MUL_DIV_CTRL_REUSE_EN
    logic            ent_vld_q, ent_vld_d;
    logic [2:0]      ent_key_q, ent_key_d;
    logic [XLEN-1:0] ent_rs1_q, ent_rs1_d;
    logic [XLEN-1:0] ent_rs2_q, ent_rs2_d;
    logic [XLEN-1:0] ent_hi_q, ent_hi_d;
    logic [XLEN-1:0] ent_lo_q, ent_lo_d;
    logic            hit;

    // Ops that read different halves of the same unit run share one key.
    function automatic logic [2:0] op_key(input logic [2:0] f3);
        if (f3[2]) begin
            return {2'b10, f3[0]};
        end
        return (f3[1] == 1'b0) ? 3'b000 : f3;
    endfunction

    assign hit = ent_vld_q &&
                 (ent_rs1_q == bus.issue_rs1_i) &&
                 (ent_rs2_q == bus.issue_rs2_i) &&
                 (ent_key_q == op_key(bus.issue_funct3_i));
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        f3_d      = f3_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        data_d    = data_q;
        rs1_sgn_d = rs1_sgn_q;
        rs2_sgn_d = rs2_sgn_q;
`ifdef MUL_DIV_CTRL_REUSE_EN
        ent_vld_d = ent_vld_q;
        ent_key_d = ent_key_q;
        ent_rs1_d = ent_rs1_q;
        ent_rs2_d = ent_rs2_q;
        ent_hi_d  = ent_hi_q;
        ent_lo_d  = ent_lo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = bus.issue_op_i;
                    f3_d      = bus.issue_funct3_i;
                    rs1_d     = bus.issue_rs1_i;
                    rs2_d     = bus.issue_rs2_i;
                    rd_d      = bus.issue_rd_i;
                    rs1_sgn_d = rs1_signed(bus.issue_funct3_i);
                    rs2_sgn_d = rs2_signed(bus.issue_funct3_i);
                    state_d   = ST_BUSY;
`ifdef MUL_DIV_CTRL_REUSE_EN
                    if (hit) begin
                        state_d = ST_RESP;
                        data_d  = take_high(bus.issue_funct3_i) ? ent_hi_q : ent_lo_q;
                    end
`endif
                end
            end
            ST_BUSY: begin
                if (bus.md_ready_i) begin
                    state_d = ST_RESP;
                    data_d  = take_high(f3_q) ? bus.md_high_i : bus.md_low_i;
`ifdef MUL_DIV_CTRL_REUSE_EN
                    ent_vld_d = 1'b1;
                    ent_key_d = op_key(f3_q);
                    ent_rs1_d = rs1_q;
                    ent_rs2_d = rs2_q;
                    ent_hi_d  = bus.md_high_i;
                    ent_lo_d  = bus.md_low_i;
`endif
                end
            end
            ST_RESP: begin
                if (bus.wb_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An aborted op must leave no trace in the reuse entry either.
        if (bus.flush_i) begin
            state_d = ST_IDLE;
`ifdef MUL_DIV_CTRL_REUSE_EN
            ent_vld_d = ent_vld_q;
            ent_key_d = ent_key_q;
            ent_rs1_d = ent_rs1_q;
            ent_rs2_d = ent_rs2_q;
            ent_hi_d  = ent_hi_q;
            ent_lo_d  = ent_lo_q;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            f3_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            rs1_sgn_q <= 1'b0;
            rs2_sgn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            f3_q      <= f3_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            rs1_sgn_q <= rs1_sgn_d;
            rs2_sgn_q <= rs2_sgn_d;
        end
    end

`ifdef MUL_DIV_CTRL_REUSE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_vld_q <= 1'b0;
            ent_key_q <= '0;
            ent_rs1_q <= '0;
            ent_rs2_q <= '0;
            ent_hi_q  <= '0;
            ent_lo_q  <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            ent_key_q <= ent_key_d;
            ent_rs1_q <= ent_rs1_d;
            ent_rs2_q <= ent_rs2_d;
            ent_hi_q  <= ent_hi_d;
            ent_lo_q  <= ent_lo_d;
        end
    end
`endif

    assign bus.issue_ready_o   = (state_q == ST_IDLE) && !rst_i && !bus.flush_i;
    assign bus.md_req_o        = (state_q == ST_BUSY);
    assign bus.md_op_o         = op_q;
    assign bus.md_m_d_op_o     = f3_q;
    assign bus.md_rs1_o        = rs1_q;
    assign bus.md_rs2_o        = rs2_q;
    assign bus.md_rs1_signed_o = rs1_sgn_q;
    assign bus.md_rs2_signed_o = rs2_sgn_q;
    assign bus.wb_valid_o      = (state_q == ST_RESP);
    assign bus.wb_rd_o         = rd_q;
    assign bus.wb_data_o       = data_q;
    assign bus.busy_o          = (state_q != ST_IDLE);
endmodule
